// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned WAIT_W     = 4;

  typedef enum logic {
    REQ_P0 = 1'b0,
    REQ_P1 = 1'b1
  } req_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // One-hot register mask with x0 always excluded.
  function automatic logic [31:0] nz_onehot(input reg_addr_t r);
    return (32'd1 << r) & ~32'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, scoreboard set/query and register-file write port.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic      p0_valid;
  logic      p0_ready;
  reg_addr_t p0_rd;
  xlen_t     p0_data;
  logic      p1_valid;
  logic      p1_ready;
  reg_addr_t p1_rd;
  xlen_t     p1_data;
  logic      sb_set_valid;
  reg_addr_t sb_set_rd;
  reg_addr_t q_rs1;
  reg_addr_t q_rs2;
  logic      q_rs1_busy;
  logic      q_rs2_busy;
  logic      WE3;
  reg_addr_t A3;
  xlen_t     WD3;

  modport master (
    output p0_valid, p0_rd, p0_data,
    output p1_valid, p1_rd, p1_data,
    output sb_set_valid, sb_set_rd, q_rs1, q_rs2,
    input  p0_ready, p1_ready, q_rs1_busy, q_rs2_busy,
    input  WE3, A3, WD3
  );

  modport slave (
    input  p0_valid, p0_rd, p0_data,
    input  p1_valid, p1_rd, p1_data,
    input  sb_set_valid, sb_set_rd, q_rs1, q_rs2,
    output p0_ready, p1_ready, q_rs1_busy, q_rs2_busy,
    output WE3, A3, WD3
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending multi-cycle destination bitmap with two combinational query ports.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      CLK,
  input  logic      Reset,
  input  logic      set_valid,
  input  reg_addr_t set_rd,
  input  logic      clr_valid,
  input  reg_addr_t clr_rd,
  input  reg_addr_t q_rs1,
  input  reg_addr_t q_rs2,
  output logic      q_rs1_busy,
  output logic      q_rs2_busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Set is OR-ed after the clear so a same-cycle set/clear leaves the bit busy.
  always_comb begin
    set_mask = set_valid ? nz_onehot(set_rd) : '0;
    clr_mask = clr_valid ? nz_onehot(clr_rd) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign q_rs1_busy = busy_q[q_rs1];
  assign q_rs2_busy = busy_q[q_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (p0) and the multi-cycle unit (p1); tracks pending p1 destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_P0  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic              p0_grant;
  logic              p1_grant;
  logic              xfer;
  req_e              last_grant;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_d;
  reg_addr_t         wr_rd;
  xlen_t             wr_data;
  logic              we_q;
  reg_addr_t         a3_q;
  xlen_t             wd3_q;

  always_comb begin
    p0_grant = 1'b0;
    p1_grant = 1'b0;
    unique case ({bus.p1_valid, bus.p0_valid})
      2'b01: p0_grant = 1'b1;
      2'b10: p1_grant = 1'b1;
      2'b11: begin
        if (PRIO_P0 != 0) begin
          // p0 wins unless p1 has been refused long enough
          if (wait_cnt == WAIT_LIM) p1_grant = 1'b1;
          else                      p0_grant = 1'b1;
        end else begin
          if (last_grant == REQ_P1) p0_grant = 1'b1;
          else                      p1_grant = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.p0_ready = p0_grant;
  assign bus.p1_ready = p1_grant;

  always_comb begin
    xfer    = p0_grant | p1_grant;
    wr_rd   = p1_grant ? bus.p1_rd   : bus.p0_rd;
    wr_data = p1_grant ? bus.p1_data : bus.p0_data;
  end

  always_comb begin
    wait_cnt_d = '0;
    if (bus.p1_valid && !p1_grant) begin
      wait_cnt_d = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      last_grant <= REQ_P1;
      wait_cnt   <= '0;
    end else begin
      wait_cnt <= wait_cnt_d;
      if (p1_grant)      last_grant <= REQ_P1;
      else if (p0_grant) last_grant <= REQ_P0;
    end
  end

  // x0 transfers complete normally but never raise the write enable.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else if (xfer) begin
      we_q  <= (wr_rd != '0);
      a3_q  <= wr_rd;
      wd3_q <= wr_data;
    end else begin
      we_q  <= 1'b0;
    end
  end

  assign bus.WE3 = we_q;
  assign bus.A3  = a3_q;
  assign bus.WD3 = wd3_q;

  wb_scoreboard u_sb (
    .CLK        (CLK),
    .Reset      (Reset),
    .set_valid  (bus.sb_set_valid),
    .set_rd     (bus.sb_set_rd),
    .clr_valid  (p1_grant),
    .clr_rd     (bus.p1_rd),
    .q_rs1      (bus.q_rs1),
    .q_rs2      (bus.q_rs2),
    .q_rs1_busy (bus.q_rs1_busy),
    .q_rs2_busy (bus.q_rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench: round-robin (index 0) and priority (index 1) instances with a
// rule-level reference model, directed vector tables and random traffic.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned MAXW = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        p0v [2];
  logic [4:0]  p0rd [2];
  logic [31:0] p0d [2];
  logic        p1v [2];
  logic [4:0]  p1rd [2];
  logic [31:0] p1d [2];
  logic        sbs [2];
  logic [4:0]  sbrd [2];
  logic [4:0]  q1 [2];
  logic [4:0]  q2 [2];
  logic        p0r [2];
  logic        p1r [2];
  logic        b1 [2];
  logic        b2 [2];
  logic        we [2];
  logic [4:0]  a3 [2];
  logic [31:0] wd3 [2];

  regfile_wb_arbiter_if bus0 ();
  regfile_wb_arbiter_if bus1 ();

  assign bus0.p0_valid = p0v[0];  assign bus1.p0_valid = p0v[1];
  assign bus0.p0_rd    = p0rd[0]; assign bus1.p0_rd    = p0rd[1];
  assign bus0.p0_data  = p0d[0];  assign bus1.p0_data  = p0d[1];
  assign bus0.p1_valid = p1v[0];  assign bus1.p1_valid = p1v[1];
  assign bus0.p1_rd    = p1rd[0]; assign bus1.p1_rd    = p1rd[1];
  assign bus0.p1_data  = p1d[0];  assign bus1.p1_data  = p1d[1];
  assign bus0.sb_set_valid = sbs[0];  assign bus1.sb_set_valid = sbs[1];
  assign bus0.sb_set_rd    = sbrd[0]; assign bus1.sb_set_rd    = sbrd[1];
  assign bus0.q_rs1 = q1[0]; assign bus1.q_rs1 = q1[1];
  assign bus0.q_rs2 = q2[0]; assign bus1.q_rs2 = q2[1];
  assign p0r[0] = bus0.p0_ready;   assign p0r[1] = bus1.p0_ready;
  assign p1r[0] = bus0.p1_ready;   assign p1r[1] = bus1.p1_ready;
  assign b1[0]  = bus0.q_rs1_busy; assign b1[1]  = bus1.q_rs1_busy;
  assign b2[0]  = bus0.q_rs2_busy; assign b2[1]  = bus1.q_rs2_busy;
  assign we[0]  = bus0.WE3; assign we[1]  = bus1.WE3;
  assign a3[0]  = bus0.A3;  assign a3[1]  = bus1.A3;
  assign wd3[0] = bus0.WD3; assign wd3[1] = bus1.WD3;

  regfile_wb_arbiter #(.PRIO_P0(0), .MAX_WAIT(MAXW)) dut_rr (
    .CLK(CLK), .Reset(Reset), .bus(bus0));
  regfile_wb_arbiter #(.PRIO_P0(1), .MAX_WAIT(MAXW)) dut_pr (
    .CLK(CLK), .Reset(Reset), .bus(bus1));

  typedef struct {
    bit p0v; logic [4:0] p0rd; logic [31:0] p0d;
    bit p1v; logic [4:0] p1rd; logic [31:0] p1d;
    bit sbs; logic [4:0] sbrd; logic [4:0] q1; logic [4:0] q2;
    bit e0; bit e1; bit ewe; logic [4:0] ea3; logic [31:0] ewd; bit eb1; bit eb2;
  } vec_t;

  vec_t rr_tbl [7];
  vec_t pr_tbl [24];
  vec_t nov;

  // Reference model state
  bit          mbusy [2][32];
  int          mlast [2];
  int          mwait [2];
  bit          mwe [2];
  logic [4:0]  ma3 [2];
  logic [31:0] mwd [2];
  bit          acc0 [2];
  bit          acc1 [2];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) mbusy[d][r] = 1'b0;
      mlast[d] = 1; mwait[d] = 0; mwe[d] = 1'b0; ma3[d] = '0; mwd[d] = '0;
      acc0[d] = 1'b1; acc1[d] = 1'b1;
    end
  endtask

  function automatic void grants(input int d, output bit g0, output bit g1);
    g0 = 1'b0; g1 = 1'b0;
    if (p0v[d] && p1v[d]) begin
      if (d == 1) begin
        if (mwait[d] == MAXW) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        if (mlast[d] == 1) g0 = 1'b1; else g1 = 1'b1;
      end
    end else if (p0v[d]) g0 = 1'b1;
    else if (p1v[d]) g1 = 1'b1;
  endfunction

  task automatic check_model(input int d);
    bit g0, g1;
    grants(d, g0, g1);
    chk($sformatf("d%0d p0_ready", d), 32'(p0r[d]), 32'(g0));
    chk($sformatf("d%0d p1_ready", d), 32'(p1r[d]), 32'(g1));
    chk($sformatf("d%0d WE3", d), 32'(we[d]), 32'(mwe[d]));
    if (mwe[d]) begin
      chk($sformatf("d%0d A3", d), 32'(a3[d]), 32'(ma3[d]));
      chk($sformatf("d%0d WD3", d), wd3[d], mwd[d]);
    end
    chk($sformatf("d%0d q_rs1_busy", d), 32'(b1[d]), 32'(mbusy[d][q1[d]]));
    chk($sformatf("d%0d q_rs2_busy", d), 32'(b2[d]), 32'(mbusy[d][q2[d]]));
  endtask

  task automatic update_model(input int d);
    bit g0, g1;
    grants(d, g0, g1);
    if (g0 || g1) begin
      mwe[d] = g1 ? (p1rd[d] != 0) : (p0rd[d] != 0);
      ma3[d] = g1 ? p1rd[d] : p0rd[d];
      mwd[d] = g1 ? p1d[d] : p0d[d];
      mlast[d] = g1 ? 1 : 0;
    end else begin
      mwe[d] = 1'b0;
    end
    if (p1v[d] && !g1) mwait[d] = (mwait[d] < MAXW) ? mwait[d] + 1 : MAXW;
    else mwait[d] = 0;
    if (g1 && p1rd[d] != 0) mbusy[d][p1rd[d]] = 1'b0;
    if (sbs[d] && sbrd[d] != 0) mbusy[d][sbrd[d]] = 1'b1;
    acc0[d] = g0;
    acc1[d] = g1;
  endtask

  task automatic drive_idle(input int d);
    p0v[d] = 1'b0; p0rd[d] = '0; p0d[d] = '0;
    p1v[d] = 1'b0; p1rd[d] = '0; p1d[d] = '0;
    sbs[d] = 1'b0; sbrd[d] = '0; q1[d] = '0; q2[d] = '0;
  endtask

  task automatic drive_vec(input int d, input vec_t v);
    drive_idle(1 - d);
    p0v[d] = v.p0v; p0rd[d] = v.p0rd; p0d[d] = v.p0d;
    p1v[d] = v.p1v; p1rd[d] = v.p1rd; p1d[d] = v.p1d;
    sbs[d] = v.sbs; sbrd[d] = v.sbrd; q1[d] = v.q1; q2[d] = v.q2;
  endtask

  task automatic run_cycle(input bit has_v, input int d, input vec_t v, input int idx);
    @(negedge CLK);
    check_model(0);
    check_model(1);
    if (has_v) begin
      chk($sformatf("vec d%0d[%0d] p0_ready", d, idx), 32'(p0r[d]), 32'(v.e0));
      chk($sformatf("vec d%0d[%0d] p1_ready", d, idx), 32'(p1r[d]), 32'(v.e1));
      chk($sformatf("vec d%0d[%0d] WE3", d, idx), 32'(we[d]), 32'(v.ewe));
      if (v.ewe) begin
        chk($sformatf("vec d%0d[%0d] A3", d, idx), 32'(a3[d]), 32'(v.ea3));
        chk($sformatf("vec d%0d[%0d] WD3", d, idx), wd3[d], v.ewd);
      end
      chk($sformatf("vec d%0d[%0d] busy1", d, idx), 32'(b1[d]), 32'(v.eb1));
      chk($sformatf("vec d%0d[%0d] busy2", d, idx), 32'(b2[d]), 32'(v.eb2));
    end
    update_model(0);
    update_model(1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nov = '{default: 0};
    // {p0v,p0rd,p0d, p1v,p1rd,p1d, sbs,sbrd, q1,q2, e0,e1, ewe,ea3,ewd, eb1,eb2}
    rr_tbl[0] = '{1,1,'h10, 1,2,'h20, 0,0, 0,0, 1,0, 0,0,0,     0,0};
    rr_tbl[1] = '{1,1,'h11, 1,2,'h20, 0,0, 0,0, 0,1, 1,1,'h10,  0,0};
    rr_tbl[2] = '{1,1,'h11, 1,2,'h21, 0,0, 0,0, 1,0, 1,2,'h20,  0,0};
    rr_tbl[3] = '{1,1,'h12, 1,2,'h21, 0,0, 0,0, 0,1, 1,1,'h11,  0,0};
    rr_tbl[4] = '{1,1,'h12, 0,0,0,    0,0, 0,0, 1,0, 1,2,'h21,  0,0};
    rr_tbl[5] = '{0,0,0,    0,0,0,    0,0, 0,0, 0,0, 1,1,'h12,  0,0};
    rr_tbl[6] = '{0,0,0,    0,0,0,    0,0, 0,0, 0,0, 0,0,0,     0,0};

    pr_tbl[0]  = '{1,3,'h11, 0,0,0,          0,0, 3,0, 1,0, 0,0,0,         0,0};
    pr_tbl[1]  = '{0,0,0,    0,0,0,          0,0, 3,0, 0,0, 1,3,'h11,      0,0};
    pr_tbl[2]  = '{0,0,0,    0,0,0,          0,0, 0,0, 0,0, 0,0,0,         0,0};
    pr_tbl[3]  = '{0,0,0,    0,0,0,          1,9, 9,0, 0,0, 0,0,0,         0,0};
    pr_tbl[4]  = '{0,0,0,    0,0,0,          0,0, 9,0, 0,0, 0,0,0,         1,0};
    pr_tbl[5]  = '{0,0,0,    1,9,'h99,       0,0, 9,0, 0,1, 0,0,0,         1,0};
    pr_tbl[6]  = '{0,0,0,    0,0,0,          0,0, 9,0, 0,0, 1,9,'h99,      0,0};
    pr_tbl[7]  = '{0,0,0,    0,0,0,          1,9, 9,0, 0,0, 0,0,0,         0,0};
    pr_tbl[8]  = '{0,0,0,    1,9,'h77,       1,9, 9,0, 0,1, 0,0,0,         1,0};
    pr_tbl[9]  = '{0,0,0,    0,0,0,          0,0, 9,0, 0,0, 1,9,'h77,      1,0};
    pr_tbl[10] = '{0,0,0,    1,0,'hFFFFFFFF, 0,0, 0,9, 0,1, 0,0,0,         0,1};
    pr_tbl[11] = '{0,0,0,    0,0,0,          0,0, 0,9, 0,0, 0,0,0,         0,1};
    pr_tbl[12] = '{0,0,0,    1,9,'h1,        0,0, 0,9, 0,1, 0,0,0,         0,1};
    pr_tbl[13] = '{0,0,0,    0,0,0,          0,0, 0,9, 0,0, 1,9,'h1,       0,0};
    pr_tbl[14] = '{1,1,'hA0, 1,7,'h7777,     0,0, 0,0, 1,0, 0,0,0,         0,0};
    pr_tbl[15] = '{1,1,'hA1, 1,7,'h7777,     0,0, 0,0, 1,0, 1,1,'hA0,      0,0};
    pr_tbl[16] = '{1,1,'hA2, 1,7,'h7777,     0,0, 0,0, 1,0, 1,1,'hA1,      0,0};
    pr_tbl[17] = '{1,1,'hA3, 1,7,'h7777,     0,0, 0,0, 1,0, 1,1,'hA2,      0,0};
    pr_tbl[18] = '{1,1,'hA4, 1,7,'h7777,     0,0, 0,0, 0,1, 1,1,'hA3,      0,0};
    pr_tbl[19] = '{1,1,'hA4, 0,0,0,          0,0, 0,0, 1,0, 1,7,'h7777,    0,0};
    pr_tbl[20] = '{1,1,'hA5, 1,8,'h88,       0,0, 0,0, 1,0, 1,1,'hA4,      0,0};
    pr_tbl[21] = '{0,0,0,    1,8,'h88,       0,0, 0,0, 0,1, 1,1,'hA5,      0,0};
    pr_tbl[22] = '{0,0,0,    0,0,0,          0,0, 0,0, 0,0, 1,8,'h88,      0,0};
    pr_tbl[23] = '{0,0,0,    0,0,0,          0,0, 0,0, 0,0, 0,0,0,         0,0};

    drive_idle(0);
    drive_idle(1);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset d%0d WE3", d), 32'(we[d]), 32'd0);
      chk($sformatf("reset d%0d A3", d), 32'(a3[d]), 32'd0);
      chk($sformatf("reset d%0d WD3", d), wd3[d], 32'd0);
    end
    Reset = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 7; i++) begin
      drive_vec(0, rr_tbl[i]);
      run_cycle(1'b1, 0, rr_tbl[i], i);
    end
    for (int i = 0; i < 24; i++) begin
      drive_vec(1, pr_tbl[i]);
      run_cycle(1'b1, 1, pr_tbl[i], i);
    end

    // Reset arriving while an accepted write sits in the output register
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      sbs[d] = 1'b1; sbrd[d] = 5'd9;
    end
    run_cycle(1'b0, 0, nov, 0);
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      p0v[d] = 1'b1; p0rd[d] = 5'd5; p0d[d] = 32'hDEADBEEF;
    end
    run_cycle(1'b0, 0, nov, 0);
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      q1[d] = 5'd9; q2[d] = 5'd5;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pre-reset d%0d WE3", d), 32'(we[d]), 32'd1);
      chk($sformatf("pre-reset d%0d A3", d), 32'(a3[d]), 32'd5);
      chk($sformatf("pre-reset d%0d busy x9", d), 32'(b1[d]), 32'd1);
    end
    Reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async reset d%0d WE3", d), 32'(we[d]), 32'd0);
      chk($sformatf("async reset d%0d A3", d), 32'(a3[d]), 32'd0);
      chk($sformatf("async reset d%0d WD3", d), wd3[d], 32'd0);
      chk($sformatf("async reset d%0d busy x9", d), 32'(b1[d]), 32'd0);
    end
    model_reset();
    Reset = 1'b0;
    run_cycle(1'b0, 0, nov, 0);

    // Random traffic; a refused request is held until accepted
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!(p0v[d] && !acc0[d])) begin
          p0v[d]  = ($urandom_range(9, 0) < 7);
          p0rd[d] = 5'($urandom_range(31, 0));
          p0d[d]  = $urandom;
        end
        if (!(p1v[d] && !acc1[d])) begin
          p1v[d]  = ($urandom_range(9, 0) < 5);
          p1rd[d] = 5'($urandom_range(7, 0));
          p1d[d]  = $urandom;
        end
        sbs[d]  = ($urandom_range(3, 0) == 0);
        sbrd[d] = 5'($urandom_range(7, 0));
        q1[d]   = 5'($urandom_range(7, 0));
        q2[d]   = 5'($urandom_range(7, 0));
      end
      run_cycle(1'b0, 0, nov, c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) between two writeback sources. Requester 0 is the in-order pipeline writeback (ALU/load). Requester 1 is a multi-cycle unit (mul/div). The block also keeps a scoreboard of destination registers with pending multi-cycle results, so issue logic can stall on RAW hazards. It sits between the writeback stage and the register file, and replaces the direct WE3/A3/WD3 drive.

Parameters:
PRIO_P0, 1, 1 = requester 0 has fixed priority with a starvation guard; 0 = pure round-robin
MAX_WAIT, 4, consecutive cycles requester 1 may be refused before a forced grant (PRIO_P0=1 only); range 1..15

Ports:
CLK  in  1  clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-high reset
p0_valid  in  1  requester 0 has a write
p0_ready  out  1  requester 0 granted this cycle
p0_rd  in  5  requester 0 destination register
p0_data  in  32  requester 0 write data
p1_valid  in  1  requester 1 has a write
p1_ready  out  1  requester 1 granted this cycle
p1_rd  in  5  requester 1 destination register
p1_data  in  32  requester 1 write data
sb_set_valid  in  1  multi-cycle op issued this cycle
sb_set_rd  in  5  destination of the issued op
q_rs1  in  5  scoreboard query address 1
q_rs2  in  5  scoreboard query address 2
q_rs1_busy  out  1  q_rs1 has a pending multi-cycle write
q_rs2_busy  out  1  q_rs2 has a pending multi-cycle write
WE3  out  1  register-file write enable (registered)
A3  out  5  register-file write address (registered)
WD3  out  32  register-file write data (registered)

Behaviour:
- Reset (async, any time): WE3=0, A3=0, WD3=0, busy[31:1]=0, last_grant=1, wait_cnt=0. An in-flight output register is discarded, not written.
- Handshake: a transfer occurs when px_valid && px_ready in the same cycle. The ready outputs are combinational from the valids and internal state. At most one ready is high per cycle. A ready never rises without its valid.
- The output stage always drains in one cycle, so a request is never back-pressured except by losing arbitration.
- Grant rules:
  - Only one valid: grant it.
  - Both valid, PRIO_P0=0: grant the requester not granted last. last_grant updates on every transfer.
  - Both valid, PRIO_P0=1: grant p0 unless wait_cnt==MAX_WAIT, then grant p1.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle p1_valid && !p1_ready.
  - Clears on a p1 transfer or when p1_valid=0.
- Requesters must hold valid, rd and data stable until accepted.
- Latency: a transfer at edge N drives WE3=1, A3=rd, WD3=data during cycle N+1. The register file commits at edge N+1. There is no bypass, so reads in cycle N+1 return the old value.
- rd==0: the transfer still completes (ready, scoreboard effects), but WE3=0 in cycle N+1.
- Idle cycle (no transfer): WE3=0 next cycle. A3 and WD3 hold their previous values.
- Scoreboard:
  - busy[r] sets at the edge where sb_set_valid && sb_set_rd==r, r!=0.
  - busy[r] clears at the edge of a p1 transfer with p1_rd==r.
  - Set and clear of the same r in the same cycle: set wins.
  - A set on a register that is already busy keeps it busy. There is no counting; issue logic guarantees at most one outstanding op per rd.
- Queries: q_rsX_busy = busy[q_rsX] (current registered state, combinational read). x0 always reads 0.
- p0 transfers never touch the scoreboard.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, requester index constants REQ_P0=0, REQ_P1=1.
- One natural sub-module: wb_scoreboard (busy bitmap, set/clear, two query ports).
- Arbitration, wait counter and output register stay in the top module.

Test Plan:
- Reset mid-transfer: p0 write x5=0xDEADBEEF accepted, Reset asserted before the next edge -> WE3=0 immediately, no write to x5, busy=0.
- p0 alone: x3=0x11 -> p0_ready=1 same cycle; next cycle WE3=1, A3=3, WD3=0x11; following cycle WE3=0.
- PRIO_P0=0, both valid for 4 cycles (p0: x1 values, p1: x2 values) -> grants alternate p0,p1,p0,p1; A3 sequence 1,2,1,2.
- PRIO_P0=1, MAX_WAIT=4, p0 valid every cycle, p1 valid on x7 -> p1_ready on the 5th cycle; exactly one p1 write of x7; wait_cnt returns to 0.
- Scoreboard: sb_set x9 -> next cycle q_rs1=9 busy=1; p1 write x9 -> busy=0 the cycle after; in a cycle with both sb_set x9 and p1 clear x9, busy stays 1.
- rd=0 write from p1 with data 0xFFFFFFFF -> p1_ready=1, WE3 stays 0, q_rs1=0 busy=0.
